// File: rtl/alu_pkg.sv
// Shared ALU control codes used by the decoder and the ALU request arbiter.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_SUB  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester after rr_ptr wins (pure combinational).
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  int j;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (!grant_valid && eligible[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = IW'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grants and one result slot each.
// Optional per-requester grant/stall counters are built when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NREQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*ALU_OP_W-1:0]    req_op,
  input  logic [NREQ*REG_WIDTH-1:0]   req_in1,
  input  logic [NREQ*REG_WIDTH-1:0]   req_in2,
  output logic [NREQ-1:0]             resp_valid,
  input  logic [NREQ-1:0]             resp_ready,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ*16-1:0]          stat_grant_cnt,
  output logic [NREQ*16-1:0]          stat_stall_cnt,
`endif
  output logic [NREQ*REG_WIDTH-1:0]   resp_result
);

  localparam int IW  = $clog2(NREQ);
  localparam int SHW = $clog2(REG_WIDTH);

  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      resp_valid_q, resp_valid_d;
  logic [REG_WIDTH-1:0] resp_result_q [NREQ];
  logic [REG_WIDTH-1:0] resp_result_d [NREQ];

  logic [ALU_OP_W-1:0]  alu_op;
  logic [REG_WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [SHW-1:0]       shamt;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign eligible = {NREQ{rst_n}} & req_valid & (~resp_valid_q | resp_ready);

  rr_arbiter #(.N(NREQ)) u_rr (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign rr_ptr_d  = grant_valid ? grant_idx : rr_ptr_q;

  assign alu_op = req_op [int'(grant_idx)*ALU_OP_W  +: ALU_OP_W];
  assign alu_a  = req_in1[int'(grant_idx)*REG_WIDTH +: REG_WIDTH];
  assign alu_b  = req_in2[int'(grant_idx)*REG_WIDTH +: REG_WIDTH];
  assign shamt  = alu_b[SHW-1:0];

  always_comb begin
    alu_res = alu_a + alu_b;
    case (alu_op)
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = $signed(alu_a) >>> shamt;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLT:  alu_res = {{(REG_WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(REG_WIDTH-1){1'b0}}, (alu_a < alu_b)};
      default:  alu_res = alu_a + alu_b;
    endcase
  end

  // A new grant overrides a same-cycle drain so the slot stays full with fresh data.
  always_comb begin
    resp_valid_d = resp_valid_q;
    for (int i = 0; i < NREQ; i++) begin
      resp_result_d[i] = resp_result_q[i];
      if (grant[i]) begin
        resp_valid_d[i]  = 1'b1;
        resp_result_d[i] = alu_res;
      end else if (resp_ready[i]) begin
        resp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= IW'(NREQ-1);
      resp_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) resp_result_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      for (int i = 0; i < NREQ; i++) resp_result_q[i] <= resp_result_d[i];
    end
  end

  assign resp_valid = resp_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign resp_result[gi*REG_WIDTH +: REG_WIDTH] = resp_result_q[gi];

      a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    end
  endgenerate

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] grant_cnt_d [NREQ];
  logic [15:0] stall_cnt_q [NREQ];
  logic [15:0] stall_cnt_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      stall_cnt_d[i] = stall_cnt_q[i];
      if (grant[i] && grant_cnt_q[i] != 16'hFFFF)
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      if (req_valid[i] && !req_ready[i] && stall_cnt_q[i] != 16'hFFFF)
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stat
      assign stat_grant_cnt[gi*16 +: 16] = grant_cnt_q[gi];
      assign stat_stall_cnt[gi*16 +: 16] = stall_cnt_q[gi];
    end
  endgenerate
`endif

endmodule
